// File: rtl/conv_pkg.sv
// Shared sizing constants for the conv1 post-processing path (ReLU, requant, 2x2 max pool).
package conv_pkg;

  localparam int L1_SIZE       = 24;
  localparam int POOL_SIZE     = L1_SIZE / 2;
  localparam int NUM_CH        = 6;
  localparam int DEF_SHIFT     = 8;
  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 8;

  function automatic int sat_limit(input int width);
    return (1 << width) - 1;
  endfunction

  localparam int SAT_LIMIT = sat_limit(DEF_OUT_WIDTH);

endpackage

// File: rtl/conv1_relu_pool_if.sv
// Pixel stream interface between the conv1 accumulators and the pooled feature-map consumer.
interface conv1_relu_pool_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);

  // Valid-only streams: a beat transfers on every cycle its valid is high.
  // There is no ready; the consumer must take every out_valid beat.
  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_ch0;
  logic signed [IN_WIDTH-1:0]  in_ch1;
  logic signed [IN_WIDTH-1:0]  in_ch2;
  logic signed [IN_WIDTH-1:0]  in_ch3;
  logic signed [IN_WIDTH-1:0]  in_ch4;
  logic signed [IN_WIDTH-1:0]  in_ch5;
  logic                        out_valid;
  logic [OUT_WIDTH-1:0]        out_ch0;
  logic [OUT_WIDTH-1:0]        out_ch1;
  logic [OUT_WIDTH-1:0]        out_ch2;
  logic [OUT_WIDTH-1:0]        out_ch3;
  logic [OUT_WIDTH-1:0]        out_ch4;
  logic [OUT_WIDTH-1:0]        out_ch5;
  logic                        out_last;

  modport master (
    output in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5,
    input  out_valid, out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5, out_last
  );

  modport slave (
    input  in_valid, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5,
    output out_valid, out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5, out_last
  );

endinterface

// File: rtl/relu_requant.sv
// Single-channel ReLU + arithmetic right shift + unsigned saturation, purely combinational.
module relu_requant
  import conv_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic signed [IN_WIDTH-1:0] acc,
  output logic [OUT_WIDTH-1:0]       q
);

  localparam logic [IN_WIDTH-1:0] LIMIT = IN_WIDTH'(sat_limit(OUT_WIDTH));

  logic [IN_WIDTH-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    // Non-positive inputs clamp to zero before the shift is considered.
    if (acc[IN_WIDTH-1] || (acc == '0)) begin
      q = '0;
    end else if (shifted > LIMIT) begin
      q = LIMIT[OUT_WIDTH-1:0];
    end else begin
      q = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv1_relu_pool.sv
// conv1 post-processing: per-channel requant, then 2x2 stride-2 max pooling over a raster stream.
module conv1_relu_pool
  import conv_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int IN_SIZE   = L1_SIZE,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  conv1_relu_pool_if.slave  px
);

  localparam int CW   = $clog2(IN_SIZE);
  localparam int HALF = IN_SIZE / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);

  typedef logic [OUT_WIDTH-1:0] pix_t;

  logic signed [IN_WIDTH-1:0] acc [NUM_CH];
  pix_t q_comb [NUM_CH];

  assign acc[0] = px.in_ch0;
  assign acc[1] = px.in_ch1;
  assign acc[2] = px.in_ch2;
  assign acc[3] = px.in_ch3;
  assign acc[4] = px.in_ch4;
  assign acc[5] = px.in_ch5;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_rq
    relu_requant #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT    (SHIFT)
    ) u_rq (
      .acc(acc[i]),
      .q  (q_comb[i])
    );
  end

  // A pixel presented in the same cycle as clear belongs to the aborted frame.
  logic accept;
  assign accept = px.in_valid && !clear;

  logic [CW-1:0] col, row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (px.in_valid) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: requantised pixel plus its position tags.
  logic          v1;
  logic [CW-1:0] col1, row1;
  pix_t          q1 [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        col1 <= col;
        row1 <= row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) q1 <= q_comb;
  end

  // Stage 2: horizontal pair max, line buffer, vertical max.
  logic          adv2;
  logic [HW-1:0] lb_idx;
  pix_t          hold    [NUM_CH];
  pix_t          linebuf [HALF][NUM_CH];
  pix_t          h       [NUM_CH];
  pix_t          pooled  [NUM_CH];

  assign adv2   = v1 && !clear;
  assign lb_idx = HW'(col1 >> 1);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      h[i]      = (hold[i] > q1[i]) ? hold[i] : q1[i];
      pooled[i] = (linebuf[lb_idx][i] > h[i]) ? linebuf[lb_idx][i] : h[i];
    end
  end

  // Hold and line buffer are always written before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (adv2) begin
      if (!col1[0]) begin
        hold <= q1;
      end else if (!row1[0]) begin
        linebuf[lb_idx] <= h;
      end
    end
  end

  logic out_valid_r, out_last_r;
  pix_t out_d [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) out_d[i] <= '0;
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      if (adv2 && col1[0] && row1[0]) begin
        out_valid_r <= 1'b1;
        out_last_r  <= (col1 == LAST) && (row1 == LAST);
        out_d       <= pooled;
      end
    end
  end

  assign px.out_valid = out_valid_r;
  assign px.out_last  = out_last_r;
  assign px.out_ch0   = out_d[0];
  assign px.out_ch1   = out_d[1];
  assign px.out_ch2   = out_d[2];
  assign px.out_ch3   = out_d[3];
  assign px.out_ch4   = out_d[4];
  assign px.out_ch5   = out_d[5];

endmodule

// File: tb/tb_conv1_relu_pool.sv
// Self-checking bench for conv1_relu_pool: expected pooled pixels are queued as frames are driven.
module tb_conv1_relu_pool;
  import conv_pkg::*;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int N  = 24;
  localparam int P  = 12;
  localparam int SH = 8;
  localparam int EW = 6 * OW + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  conv1_relu_pool_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  conv1_relu_pool #(
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .IN_SIZE  (N),
    .SHIFT    (SH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .px   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic signed [IW-1:0] img [6][N][N];
  logic [EW-1:0]        exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  function automatic logic [EW-1:0] got_word();
    return {bus.out_last, bus.out_ch5, bus.out_ch4, bus.out_ch3,
            bus.out_ch2, bus.out_ch1, bus.out_ch0};
  endfunction

  // Reference requant, written directly from the arithmetic definition.
  function automatic logic [OW-1:0] ref_q(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    if (v <= 0) return '0;
    s = v >>> SH;
    if (s > 255) return 8'hFF;
    return s[OW-1:0];
  endfunction

  // Queue model results for every pooled pixel whose bottom-right input index is below limit.
  task automatic push_expected(input int limit);
    logic [EW-1:0] e;
    logic [OW-1:0] m, t;
    for (int pr = 0; pr < P; pr++) begin
      for (int pc = 0; pc < P; pc++) begin
        if ((2 * pr + 1) * N + 2 * pc + 1 < limit) begin
          e = '0;
          e[EW-1] = (pr == P - 1) && (pc == P - 1);
          for (int ch = 0; ch < 6; ch++) begin
            m = 0;
            for (int dr = 0; dr < 2; dr++) begin
              for (int dc = 0; dc < 2; dc++) begin
                t = ref_q(img[ch][2 * pr + dr][2 * pc + dc]);
                if (t > m) m = t;
              end
            end
            e[ch * OW +: OW] = m;
          end
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Queue a full frame in which every pooled pixel takes a fixed channel vector, except (0,0)..(0,3).
  task automatic push_frame_const(input logic [6*OW-1:0] body, input logic [6*OW-1:0] first [4]);
    for (int k = 0; k < P * P; k++) begin
      if (k < 4) exp_q.push_back({(k == P * P - 1), first[k]});
      else       exp_q.push_back({(k == P * P - 1), body});
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [EW-1:0] got, e;
    if (rst_n && bus.out_valid) begin
      got = got_word();
      n_out++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got=%h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL pooled_pixel got=%h expected=%h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input int r, input int c);
    bus.in_ch0 = img[0][r][c];
    bus.in_ch1 = img[1][r][c];
    bus.in_ch2 = img[2][r][c];
    bus.in_ch3 = img[3][r][c];
    bus.in_ch4 = img[4][r][c];
    bus.in_ch5 = img[5][r][c];
  endtask

  task automatic drive_pixels(input int start, input int count, input int gap_pct);
    for (int k = start; k < start + count; k++) begin
      int r, c;
      r = (k % (N * N)) / N;
      c = k % N;
      while ($urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_inputs(r, c);
    end
  endtask

  task automatic idle(input int cycles);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    set_inputs(0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_const(input logic signed [IW-1:0] v [6]);
    for (int ch = 0; ch < 6; ch++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) img[ch][r][c] = v[ch];
  endtask

  task automatic fill_random(input int lo, input int span);
    for (int ch = 0; ch < 6; ch++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) img[ch][r][c] = IW'(int'($urandom_range(0, span)) + lo);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic signed [IW-1:0] z [6];
    z = '{default: '0};
    fill_const(z);
    do_reset();
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_last} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags got=%b expected=00", {bus.out_valid, bus.out_last});
    end
    n_cmp++;
    if (got_word() !== '0) begin
      n_err++;
      $display("FAIL reset_data got=%h expected=0", got_word());
    end
  endtask

  task automatic test_constant();
    logic signed [IW-1:0] v [6];
    logic [6*OW-1:0] first [4];
    int n0;
    v     = '{default: 32'sh0000_3000};
    first = '{default: {6{8'h30}}};
    fill_const(v);
    push_frame_const({6{8'h30}}, first);
    n0 = n_out;
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (n_out - n0 != 144) begin
      n_err++;
      $display("FAIL const_count got=%0d expected=144", n_out - n0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL const_drain got=%0d expected=0", exp_q.size());
    end
    n_cmp++;
    if ({bus.out_valid, got_word()} !== {1'b0, 1'b0, {6{8'h30}}}) begin
      n_err++;
      $display("FAIL const_hold got=%h expected=%h", {bus.out_valid, got_word()}, {2'b00, {6{8'h30}}});
    end
  endtask

  task automatic test_single_peak();
    logic signed [IW-1:0] v [6];
    logic [6*OW-1:0] first [4];
    v     = '{-32'sd5000, 0, 0, 0, 0, 0};
    first = '{{40'h0, 8'd100}, 48'h0, 48'h0, 48'h0};
    fill_const(v);
    img[0][1][1] = 32'sd25600;
    push_frame_const(48'h0, first);
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL peak_drain got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    logic signed [IW-1:0] v [6];
    logic [6*OW-1:0] first [4];
    logic [6*OW-1:0] body;
    v    = '{32'sh0100_0000, 32'sd255, 32'sd256, -32'sd1, 32'sh7FFF_FFFF, 32'sh8000_0000};
    body = {8'd0, 8'd255, 8'd0, 8'd1, 8'd0, 8'd255};
    first = '{default: body};
    fill_const(v);
    push_frame_const(body, first);
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sat_drain got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_window_max();
    logic signed [IW-1:0] z [6];
    logic [6*OW-1:0] first [4];
    int vals [4];
    z     = '{default: '0};
    first = '{default: {6{8'd40}}};
    vals  = '{10, 40, 20, 30};
    fill_const(z);
    // Window w rotates the values so the 40 lands in a different quadrant each time.
    for (int w = 0; w < 4; w++) begin
      for (int ch = 0; ch < 6; ch++) begin
        img[ch][0][2 * w]     = IW'(vals[(0 + w) % 4] * 256);
        img[ch][0][2 * w + 1] = IW'(vals[(1 + w) % 4] * 256);
        img[ch][1][2 * w]     = IW'(vals[(2 + w) % 4] * 256);
        img[ch][1][2 * w + 1] = IW'(vals[(3 + w) % 4] * 256);
      end
    end
    push_frame_const(48'h0, first);
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL window_drain got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back_gaps();
    int n0;
    fill_random(-20000, 90000);
    push_expected(N * N);
    push_expected(N * N);
    push_expected(N * N);
    n0 = n_out;
    drive_pixels(0, N * N, 0);
    drive_pixels(0, 2 * N * N, 30);
    idle(4);
    n_cmp++;
    if (n_out - n0 != 3 * 144) begin
      n_err++;
      $display("FAIL gaps_count got=%0d expected=%0d", n_out - n0, 3 * 144);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL gaps_drain got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_clear();
    int cut;
    cut = 13 * N + 7;
    fill_random(-20000, 90000);
    push_expected(cut);
    drive_pixels(0, cut, 0);
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    set_inputs(13, 7);
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clear_drain got=%0d expected=0", exp_q.size());
    end
    fill_random(0, 70000);
    push_expected(N * N);
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clear_refill got=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cut;
    cut = N + 4;
    fill_random(256, 60000);
    push_expected(cut - 1);
    drive_pixels(0, cut, 0);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, got_word()} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_out got=%h expected=0", {bus.out_valid, got_word()});
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_mid_drain got=%0d expected=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random(-20000, 90000);
    push_expected(N * N);
    drive_pixels(0, N * N, 0);
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rst_refill got=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_single_peak();
    test_saturation();
    test_window_max();
    test_back_to_back_gaps();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
